// File: rtl/uart_frame_parser.sv
// uart_frame_parser: assembles 0x55 0xAA LEN CMD PAYLOAD[LEN] CHK frames from a
// UART byte strobe, buffers the payload and replays it on a valid/ready stream
// only when the modulo-256 checksum of LEN, CMD and payload matches.
module uart_frame_parser #(
  parameter int MAX_LEN      = 16,
  parameter int TIMEOUT_CLKS = 104_160
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic [7:0] frm_cmd,
  output logic [7:0] frm_len,
  output logic       frame_ok,
  output logic       err_chk,
  output logic       err_len,
  output logic       err_tmo,
  output logic       rx_drop,
  output logic       busy
);

  // Buffer address width; a 1-deep buffer still needs a 1-bit index.
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  // Timeout counter only has to hold TIMEOUT_CLKS-1.
  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR1,
    S_LEN,
    S_CMD,
    S_PAY,
    S_CHK,
    S_OUT
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      sum_q, sum_d;
  logic [7:0]      wr_ptr_q, wr_ptr_d;
  logic [7:0]      rd_ptr_q, rd_ptr_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [7:0]      m_data_q, m_data_d;
  logic            m_valid_q, m_valid_d;
  logic [7:0]      frm_cmd_q, frm_cmd_d;
  logic [7:0]      frm_len_q, frm_len_d;
  logic            frame_ok_q, frame_ok_d;
  logic            err_chk_q, err_chk_d;
  logic            err_len_q, err_len_d;
  logic            err_tmo_q, err_tmo_d;
  logic            rx_drop_q, rx_drop_d;
  logic            mem_we;
  logic [7:0]      rd_nxt;
  logic            last_beat;
  logic            in_frame;

  logic [7:0] pay_mem [MAX_LEN];

  assign rd_nxt    = rd_ptr_q + 8'd1;
  assign last_beat = m_valid_q && (rd_ptr_q == len_q - 8'd1);
  // States in which a silent line aborts the partial frame.
  assign in_frame  = (state_q == S_HDR1) || (state_q == S_LEN) || (state_q == S_CMD) ||
                     (state_q == S_PAY)  || (state_q == S_CHK);

  assign m_data   = m_data_q;
  assign m_valid  = m_valid_q;
  assign m_last   = last_beat;
  assign frm_cmd  = frm_cmd_q;
  assign frm_len  = frm_len_q;
  assign frame_ok = frame_ok_q;
  assign err_chk  = err_chk_q;
  assign err_len  = err_len_q;
  assign err_tmo  = err_tmo_q;
  assign rx_drop  = rx_drop_q;
  assign busy     = (state_q != S_IDLE);

  // Next-state, datapath and pulse generation for the frame FSM.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cmd_d      = cmd_q;
    sum_d      = sum_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    tmo_d      = '0;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    frm_cmd_d  = frm_cmd_q;
    frm_len_d  = frm_len_q;
    frame_ok_d = 1'b0;
    err_chk_d  = 1'b0;
    err_len_d  = 1'b0;
    err_tmo_d  = 1'b0;
    rx_drop_d  = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pi_flag && pi_data == 8'h55) state_d = S_HDR1;
      end
      S_HDR1: begin
        // A repeated 0x55 may be the real start of a frame, so keep waiting for 0xAA.
        if (pi_flag) begin
          if (pi_data == 8'hAA)      state_d = S_LEN;
          else if (pi_data != 8'h55) state_d = S_IDLE;
        end
      end
      S_LEN: begin
        if (pi_flag) begin
          if (pi_data != 8'd0 && pi_data <= MAX_LEN_B) begin
            len_d   = pi_data;
            sum_d   = pi_data;
            state_d = S_CMD;
          end else begin
            err_len_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_CMD: begin
        if (pi_flag) begin
          cmd_d    = pi_data;
          sum_d    = sum_q + pi_data;
          wr_ptr_d = 8'd0;
          state_d  = S_PAY;
        end
      end
      S_PAY: begin
        if (pi_flag) begin
          mem_we   = 1'b1;
          sum_d    = sum_q + pi_data;
          wr_ptr_d = wr_ptr_q + 8'd1;
          if (wr_ptr_q == len_q - 8'd1) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (pi_flag) begin
          if (pi_data == sum_q) begin
            frame_ok_d = 1'b1;
            frm_cmd_d  = cmd_q;
            frm_len_d  = len_q;
            rd_ptr_d   = 8'd0;
            state_d    = S_OUT;
          end else begin
            err_chk_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_OUT: begin
        // Receiver cannot be stalled: anything arriving now is lost.
        rx_drop_d = pi_flag;
        if (!m_valid_q) begin
          // First cycle after frame_ok: present beat 0.
          m_data_d  = pay_mem[rd_ptr_q[AW-1:0]];
          m_valid_d = 1'b1;
        end else if (m_ready) begin
          if (last_beat) begin
            m_valid_d = 1'b0;
            state_d   = S_IDLE;
          end else begin
            rd_ptr_d = rd_nxt;
            m_data_d = pay_mem[rd_nxt[AW-1:0]];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte timeout; an arriving byte always beats expiry.
    if (in_frame && !pi_flag) begin
      if (tmo_q == TMO_MAX) begin
        err_tmo_d = 1'b1;
        state_d   = S_IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      cmd_q      <= '0;
      sum_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tmo_q      <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      frm_cmd_q  <= '0;
      frm_len_q  <= '0;
      frame_ok_q <= 1'b0;
      err_chk_q  <= 1'b0;
      err_len_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
      rx_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cmd_q      <= cmd_d;
      sum_q      <= sum_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tmo_q      <= tmo_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      frm_cmd_q  <= frm_cmd_d;
      frm_len_q  <= frm_len_d;
      frame_ok_q <= frame_ok_d;
      err_chk_q  <= err_chk_d;
      err_len_q  <= err_len_d;
      err_tmo_q  <= err_tmo_d;
      rx_drop_q  <= rx_drop_d;
    end
  end

  // Payload buffer; contents are don't-care until written, so no reset.
  always_ff @(posedge sys_clk) begin
    if (mem_we) pay_mem[wr_ptr_q[AW-1:0]] <= pi_data;
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: randomized frames scored against a frame-level model.
module tb_uart_frame_parser;
  localparam int MAX_LEN = 16;
  localparam int TMO     = 40;
  localparam logic [7:0] E_OK = 8'd1, E_CHK = 8'd2, E_LEN = 8'd3, E_TMO = 8'd4, E_DROP = 8'd5;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [7:0] pi_data;
  logic       pi_flag;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic       m_last;
  logic [7:0] frm_cmd, frm_len;
  logic       frame_ok, err_chk, err_len, err_tmo, rx_drop, busy;

  uart_frame_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CLKS(TMO)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .pi_data(pi_data), .pi_flag(pi_flag),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .frm_cmd(frm_cmd), .frm_len(frm_len), .frame_ok(frame_ok), .err_chk(err_chk),
    .err_len(err_len), .err_tmo(err_tmo), .rx_drop(rx_drop), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int fails  = 0;
  int rmode  = 0;
  logic [31:0] exp_evt[$], got_evt[$];
  logic [8:0]  exp_beat[$], got_beat[$];
  logic [7:0]  pay[256];
  logic [7:0]  last_cmd = 8'h0, last_len = 8'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // m_ready pattern: 0 always ready, 1 toggle, 2 random, 3 stalled.
  initial forever begin
    @(posedge sys_clk); #1;
    case (rmode)
      0: m_ready = 1'b1;
      1: m_ready = ~m_ready;
      2: m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  // Monitor: collect pulses and beats, check stall stability and pulse exclusivity.
  logic       prev_vld = 1'b0, prev_rdy = 1'b0, prev_ok = 1'b0;
  logic [7:0] prev_dat = 8'h0;
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      prev_vld = 1'b0; prev_ok = 1'b0;
    end else begin
      int n;
      n = int'(frame_ok) + int'(err_chk) + int'(err_len) + int'(err_tmo);
      if (n != 0) chk("pulse_excl", (n <= 1), 1);
      if (frame_ok) begin
        got_evt.push_back({E_OK, frm_cmd, frm_len, 8'h0});
        chk("vld_early", m_valid, 1'b0);
      end
      if (err_chk) got_evt.push_back({E_CHK, 24'h0});
      if (err_len) got_evt.push_back({E_LEN, 24'h0});
      if (err_tmo) got_evt.push_back({E_TMO, 24'h0});
      if (rx_drop) got_evt.push_back({E_DROP, 24'h0});
      if (prev_ok) chk("vld_after_ok", m_valid, 1'b1);
      if (prev_vld && !prev_rdy) begin
        chk("stall_vld", m_valid, 1'b1);
        chk("stall_dat", m_data, prev_dat);
      end
      if (m_valid && m_ready) got_beat.push_back({m_last, m_data});
      prev_vld = m_valid; prev_rdy = m_ready; prev_dat = m_data; prev_ok = frame_ok;
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge sys_clk);
    @(posedge sys_clk); #1;
    pi_data = b; pi_flag = 1'b1;
    @(posedge sys_clk); #1;
    pi_flag = 1'b0; pi_data = 8'($urandom);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge sys_clk);
      if (!busy && !m_valid) break;
    end
    if (k == 3000) chk("idle_wait_expired", 0, 1);
    repeat (2) @(posedge sys_clk);
  endtask

  task automatic cmp_q(input string tag);
    chk({tag, "_evt_n"}, got_evt.size(), exp_evt.size());
    for (int i = 0; i < got_evt.size() && i < exp_evt.size(); i++)
      chk({tag, "_evt"}, got_evt[i], exp_evt[i]);
    chk({tag, "_beat_n"}, got_beat.size(), exp_beat.size());
    for (int i = 0; i < got_beat.size() && i < exp_beat.size(); i++)
      chk({tag, "_beat"}, 32'(got_beat[i]), 32'(exp_beat[i]));
    got_evt.delete(); exp_evt.delete(); got_beat.delete(); exp_beat.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, m_valid, 0);  chk({tag, "_data"}, m_data, 0);
    chk({tag, "_last"}, m_last, 0);    chk({tag, "_cmd"}, frm_cmd, 0);
    chk({tag, "_len"}, frm_len, 0);    chk({tag, "_ok"}, frame_ok, 0);
    chk({tag, "_echk"}, err_chk, 0);   chk({tag, "_elen"}, err_len, 0);
    chk({tag, "_etmo"}, err_tmo, 0);   chk({tag, "_drop"}, rx_drop, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Model: outcome follows from LEN range and the modulo-256 sum; xr != 0 corrupts CHK.
  task automatic run_frame(input int len, input logic [7:0] cmd, input logic [7:0] xr,
                           input int gapmax, input bit drop, input bit no_wait);
    int sum;
    send(8'h55, $urandom_range(0, gapmax));
    send(8'hAA, $urandom_range(0, gapmax));
    send(8'(len), $urandom_range(0, gapmax));
    if (len == 0 || len > MAX_LEN) begin
      exp_evt.push_back({E_LEN, 24'h0});
    end else begin
      send(cmd, $urandom_range(0, gapmax));
      sum = len + int'(cmd);
      for (int i = 0; i < len; i++) begin
        send(pay[i], $urandom_range(0, gapmax));
        sum += int'(pay[i]);
      end
      send(8'(sum % 256) ^ xr, $urandom_range(0, gapmax));
      if (xr != 8'h0) begin
        exp_evt.push_back({E_CHK, 24'h0});
      end else begin
        exp_evt.push_back({E_OK, cmd, 8'(len), 8'h0});
        last_cmd = cmd; last_len = 8'(len);
        if (!no_wait)
          for (int i = 0; i < len; i++) exp_beat.push_back({(i == len - 1), pay[i]});
        if (drop) begin
          send(8'h55, 0);
          exp_evt.push_back({E_DROP, 24'h0});
        end
      end
    end
    if (!no_wait) wait_idle();
  endtask

  initial begin
    sys_rst = 1'b1; pi_flag = 1'b0; pi_data = 8'h0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk); chk_zero("rst");
    @(posedge sys_clk); #1 sys_rst = 1'b0;

    // 1: reference frame
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
    run_frame(3, 8'h10, 8'h00, 0, 0, 0);
    chk("t1_cmd", frm_cmd, 8'h10); chk("t1_len", frm_len, 8'h03);
    cmp_q("t1");

    // 2: bad checksum (0x18), then a good frame
    run_frame(3, 8'h10, 8'h01, 0, 0, 0);
    cmp_q("t2a");
    pay[0] = 8'hC3; pay[1] = 8'h3C;
    run_frame(2, 8'h21, 8'h00, 1, 0, 0);
    cmp_q("t2b");

    // 3: length bounds
    run_frame(0, 8'h00, 8'h00, 0, 0, 0);
    run_frame(MAX_LEN + 1, 8'h00, 8'h00, 0, 0, 0);
    for (int i = 0; i < MAX_LEN; i++) pay[i] = 8'($urandom);
    run_frame(MAX_LEN, 8'h5A, 8'h00, 0, 0, 0);
    cmp_q("t3");

    // 4: resync on a repeated 0x55
    send(8'h55, 0);
    pay[0] = 8'h7F;
    run_frame(1, 8'h20, 8'h00, 0, 0, 0);
    cmp_q("t4");

    // 5a: silence after LEN aborts after exactly TMO idle clocks
    send(8'h55, 0); send(8'hAA, 0); send(8'h03, 0);
    repeat (TMO - 1) @(posedge sys_clk);
    @(negedge sys_clk); chk("t5_tmo_early", err_tmo, 0); chk("t5_busy_pre", busy, 1);
    @(posedge sys_clk);
    @(negedge sys_clk); chk("t5_tmo", err_tmo, 1); chk("t5_busy_post", busy, 0);
    exp_evt.push_back({E_TMO, 24'h0});
    wait_idle();
    cmp_q("t5a");
    // 5b: byte in the expiry cycle is taken, frame completes
    send(8'h55, 0); send(8'hAA, 0); send(8'h03, 0);
    repeat (TMO - 2) @(posedge sys_clk);
    send(8'h44, 0); send(8'h0A, 0); send(8'h0B, 0); send(8'h0C, 0);
    send(8'(8'h03 + 8'h44 + 8'h0A + 8'h0B + 8'h0C), 0);
    exp_evt.push_back({E_OK, 8'h44, 8'h03, 8'h0});
    exp_beat.push_back({1'b0, 8'h0A}); exp_beat.push_back({1'b0, 8'h0B});
    exp_beat.push_back({1'b1, 8'h0C});
    last_cmd = 8'h44; last_len = 8'h03;
    wait_idle();
    cmp_q("t5b");

    // 6: toggling ready with a dropped 0x55 during the stream
    rmode = 1;
    for (int i = 0; i < 5; i++) pay[i] = 8'($urandom);
    run_frame(5, 8'h66, 8'h00, 0, 1, 0);
    cmp_q("t6a");
    rmode = 0;
    // reset mid-payload
    send(8'h55, 0); send(8'hAA, 0); send(8'h04, 0); send(8'h30, 0); send(8'h11, 0); send(8'h22, 0);
    @(posedge sys_clk); #1 sys_rst = 1'b1;
    @(posedge sys_clk); @(negedge sys_clk); chk_zero("rst_pay");
    @(posedge sys_clk); #1 sys_rst = 1'b0;
    last_cmd = 8'h0; last_len = 8'h0;
    // reset mid-stream while stalled
    rmode = 3;
    pay[0] = 8'h91; pay[1] = 8'h92;
    run_frame(2, 8'h77, 8'h00, 0, 0, 1);
    repeat (4) @(posedge sys_clk);
    @(negedge sys_clk); chk("t6_stalled_vld", m_valid, 1);
    @(posedge sys_clk); #1 sys_rst = 1'b1;
    @(posedge sys_clk); @(negedge sys_clk); chk_zero("rst_out");
    @(posedge sys_clk); #1 sys_rst = 1'b0;
    last_cmd = 8'h0; last_len = 8'h0;
    rmode = 0;
    repeat (2) @(posedge sys_clk);
    cmp_q("t6b");
    pay[0] = 8'hAB;
    run_frame(1, 8'h01, 8'h00, 0, 0, 0);
    cmp_q("t6c");

    // randomized frames
    for (int it = 0; it < 40; it++) begin
      int kind, len, np;
      logic [7:0] g;
      kind = $urandom_range(0, 9);
      rmode = $urandom_range(0, 2);
      np = $urandom_range(0, 2);
      for (int j = 0; j < np; j++) begin
        g = 8'($urandom);
        if (g == 8'h55) g = 8'h54;
        send(g, 0);
      end
      len = (kind == 0) ? (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255))
                        : $urandom_range(1, MAX_LEN);
      for (int i = 0; i < len && i < MAX_LEN; i++) pay[i] = 8'($urandom);
      run_frame(len, 8'($urandom), (kind == 1 || kind == 2) ? 8'($urandom_range(1, 255)) : 8'h00,
                $urandom_range(0, 5), ($urandom_range(0, 3) == 0), 0);
      chk("rnd_frm_cmd", frm_cmd, last_cmd);
      chk("rnd_frm_len", frm_len, last_len);
      cmp_q("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
